// File: rtl/fbc_pkg.sv
// ---------------------------------------------------------------------------
// fbc_pkg
//
// Shared definitions for the FBC upload arbiter:
//   - state_t         : packet framing FSM states
//   - word-format tags : header / data / pad tag bytes
//   - channel indices  : FBCi, FBCr1, FBCr2
//   - make_word()      : assembles a 64-bit upload word
//   - rr_next()        : next channel index in round-robin order (mod 3)
//   - ch_onehot()      : channel index to one-hot grant vector
// ---------------------------------------------------------------------------
package fbc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2,
        ST_PAD  = 2'd3
    } state_t;

    localparam int NUM_CH   = 3;
    localparam int SAMPLE_W = 48;
    localparam int WORD_W   = 64;
    localparam int ENC_W    = 32;
    localparam int SEQ_W    = 16;

    // Tag byte occupying word bits [63:56].
    localparam logic [7:0] HEADER_TAG_DEFAULT = 8'hA5;
    localparam logic [7:0] DATA_TAG           = 8'h00;
    localparam logic [7:0] PAD_TAG            = 8'hFF;

    localparam logic [1:0] CH_FBCI  = 2'd0;
    localparam logic [1:0] CH_FBCR1 = 2'd1;
    localparam logic [1:0] CH_FBCR2 = 2'd2;

    // Every word shares the layout {tag, 6'd0, ch, 48-bit payload}. For the
    // header the payload is {seq, enc_x}.
    function automatic logic [WORD_W-1:0] make_word(
        input logic [7:0]          tag,
        input logic [1:0]          ch,
        input logic [SAMPLE_W-1:0] payload
    );
        return {tag, 6'd0, ch, payload};
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= CH_FBCR2) ? CH_FBCI : idx + 2'd1;
    endfunction

    // Index 3 does not name a channel and maps to an empty vector.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] idx);
        logic [NUM_CH-1:0] vec;
        case (idx)
            CH_FBCI:  vec = 3'b001;
            CH_FBCR1: vec = 3'b010;
            CH_FBCR2: vec = 3'b100;
            default:  vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/fbc_rr_pick.sv
// ---------------------------------------------------------------------------
// fbc_rr_pick
//
// Combinational 3-way round-robin picker. The search starts at the channel
// after ptr and wraps modulo 3, so ptr itself has the lowest priority.
//
// Ports:
//   pending  in  3  per-channel request (valid & enabled)
//   ptr      in  2  index of the most recently granted channel
//   grant    out 3  one-hot pick, 0 when nothing is pending
//   idx      out 2  index of the picked channel (0 when nothing is pending)
// ---------------------------------------------------------------------------
module fbc_rr_pick
    import fbc_pkg::*;
(
    input  logic [NUM_CH-1:0] pending,
    input  logic [1:0]        ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [1:0]        idx
);

    logic [1:0] cand_first;
    logic [1:0] cand_second;

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values computed earlier in the same evaluation; every output gets a
    // default up front so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        grant       = '0;
        idx         = CH_FBCI;
        cand_first  = rr_next(ptr);
        cand_second = rr_next(cand_first);

        if (|(pending & ch_onehot(cand_first))) begin
            grant = ch_onehot(cand_first);
            idx   = cand_first;
        end else if (|(pending & ch_onehot(cand_second))) begin
            grant = ch_onehot(cand_second);
            idx   = cand_second;
        end else if (|(pending & ch_onehot(ptr))) begin
            grant = ch_onehot(ptr);
            idx   = ptr;
        end
    end

endmodule

// File: rtl/fbc_upload_arbiter.sv
// ---------------------------------------------------------------------------
// fbc_upload_arbiter
//
// Shares the single 64-bit Aurora FBC upload lane between FBCi, FBCr1 and
// FBCr2. One channel at a time is granted round-robin and its samples are
// framed as a header word followed by BURST_LEN data words. A packet whose
// source stalls for too long, or whose upload enable drops, is completed
// with pad words so every packet has the same length downstream.
//
// Parameters:
//   BURST_LEN    data words per packet (2..256)
//   TIMEOUT_CYC  idle DATA cycles (not counting backpressure) before padding (>= 2)
//   HEADER_TAG   tag byte of the header word
//
// Ports:
//   clk_i                 in   1    system clock
//   rst_i                 in   1    asynchronous active-high reset
//   scan_en_i             in   1    new packets start only while high
//   fbc_up_en_i           in   3    per-channel upload enable
//   encode_x_i            in   32   encoder X, latched at grant
//   src_vld_i             in   3    per-channel sample valid
//   src_data_i            in   144  channel k sample in bits [48k+47:48k]
//   src_rdy_o             out  3    per-channel sample accept (combinational)
//   aurora_almost_full_i  in   1    upload FIFO almost full
//   aurora_vout_vld_o     out  1    upload word valid (registered)
//   aurora_vout_data_o    out  64   upload word (registered)
//   grant_o               out  3    one-hot granted channel, 0 when idle
//   busy_o                out  1    high in HEAD, DATA or PAD
//   pad_evt_o             out  1    one-cycle pulse on entry to PAD
// ---------------------------------------------------------------------------
module fbc_upload_arbiter
    import fbc_pkg::*;
#(
    parameter int         BURST_LEN   = 16,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] HEADER_TAG  = HEADER_TAG_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       scan_en_i,
    input  logic [NUM_CH-1:0]          fbc_up_en_i,
    input  logic [ENC_W-1:0]           encode_x_i,
    input  logic [NUM_CH-1:0]          src_vld_i,
    input  logic [NUM_CH*SAMPLE_W-1:0] src_data_i,
    output logic [NUM_CH-1:0]          src_rdy_o,
    input  logic                       aurora_almost_full_i,
    output logic                       aurora_vout_vld_o,
    output logic [WORD_W-1:0]          aurora_vout_data_o,
    output logic [NUM_CH-1:0]          grant_o,
    output logic                       busy_o,
    output logic                       pad_evt_o
);

    localparam int BEAT_W  = (BURST_LEN > 2)   ? $clog2(BURST_LEN)   : 1;
    localparam int TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    // The timer holds the idle count reached so far; the idle cycle that
    // would bring it to TIMEOUT_CYC-1 is the one that triggers padding.
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYC - 2);

    state_t              state;
    logic [1:0]          rr_ptr;
    logic [1:0]          ch;
    logic [ENC_W-1:0]    enc_x;
    logic [SEQ_W-1:0]    seq;
    logic [BEAT_W-1:0]   beat;
    logic [TIMER_W-1:0]  timer;

    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   pick_grant;
    logic [1:0]          pick_idx;
    logic                pick_any;

    logic [SAMPLE_W-1:0] sel_sample;
    logic                sel_vld;
    logic                sel_en;
    logic                accept;

    assign pending  = src_vld_i & fbc_up_en_i;
    assign pick_any = |pick_grant;

    fbc_rr_pick u_rr_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .grant   (pick_grant),
        .idx     (pick_idx)
    );

    // Route the granted channel's sample, valid and enable.
    always_comb begin
        sel_sample = src_data_i[SAMPLE_W-1:0];
        sel_vld    = src_vld_i[0];
        sel_en     = fbc_up_en_i[0];
        case (ch)
            CH_FBCR1: begin
                sel_sample = src_data_i[2*SAMPLE_W-1:SAMPLE_W];
                sel_vld    = src_vld_i[1];
                sel_en     = fbc_up_en_i[1];
            end
            CH_FBCR2: begin
                sel_sample = src_data_i[3*SAMPLE_W-1:2*SAMPLE_W];
                sel_vld    = src_vld_i[2];
                sel_en     = fbc_up_en_i[2];
            end
            default: ;
        endcase
    end

    // grant_o is the registered one-hot of ch, so it doubles as the ready mask.
    assign src_rdy_o = (state == ST_DATA && !aurora_almost_full_i) ? grant_o : '0;
    assign accept    = (state == ST_DATA) && sel_vld && !aurora_almost_full_i;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= ST_IDLE;
            rr_ptr             <= CH_FBCR2;
            ch                 <= CH_FBCI;
            enc_x              <= '0;
            seq                <= '0;
            beat               <= '0;
            timer              <= '0;
            aurora_vout_vld_o  <= 1'b0;
            aurora_vout_data_o <= '0;
            grant_o            <= '0;
            busy_o             <= 1'b0;
            pad_evt_o          <= 1'b0;
        end else begin
            aurora_vout_vld_o <= 1'b0;
            pad_evt_o         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (scan_en_i && !aurora_almost_full_i && pick_any) begin
                        ch      <= pick_idx;
                        rr_ptr  <= pick_idx;
                        enc_x   <= encode_x_i;
                        grant_o <= pick_grant;
                        busy_o  <= 1'b1;
                        state   <= ST_HEAD;
                    end
                end

                ST_HEAD: begin
                    if (!aurora_almost_full_i) begin
                        aurora_vout_vld_o  <= 1'b1;
                        aurora_vout_data_o <= make_word(HEADER_TAG, ch, {seq, enc_x});
                        beat               <= '0;
                        timer              <= '0;
                        state              <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    // An accept takes priority over a timeout in the same cycle.
                    if (accept) begin
                        aurora_vout_vld_o  <= 1'b1;
                        aurora_vout_data_o <= make_word(DATA_TAG, ch, sel_sample);
                        timer              <= '0;
                        if (beat == LAST_BEAT) begin
                            seq     <= seq + SEQ_W'(1);
                            beat    <= '0;
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                            if (!sel_en) begin
                                pad_evt_o <= 1'b1;
                                state     <= ST_PAD;
                            end
                        end
                    end else if (!sel_en) begin
                        timer     <= '0;
                        pad_evt_o <= 1'b1;
                        state     <= ST_PAD;
                    end else if (!aurora_almost_full_i) begin
                        // Backpressure freezes the timer: a stall caused by the
                        // downstream FIFO is not the source's fault.
                        if (timer == TIMER_LIMIT) begin
                            timer     <= '0;
                            pad_evt_o <= 1'b1;
                            state     <= ST_PAD;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end

                ST_PAD: begin
                    if (!aurora_almost_full_i) begin
                        aurora_vout_vld_o  <= 1'b1;
                        aurora_vout_data_o <= make_word(PAD_TAG, ch, '0);
                        if (beat == LAST_BEAT) begin
                            seq     <= seq + SEQ_W'(1);
                            beat    <= '0;
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fbc_upload_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fbc_upload_arbiter
//
// Scoreboard bench for fbc_upload_arbiter (BURST_LEN=16, TIMEOUT_CYC=8).
// Bench-side sources offer a fixed number of samples per channel; expected
// upload words are queued as stimulus is set up (or as samples are handed
// over) and compared in order against every valid word from the DUT.
// ---------------------------------------------------------------------------
module tb_fbc_upload_arbiter;

    localparam int BURST = 16;
    localparam int TMO   = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         scan_en_i;
    logic [2:0]   fbc_up_en_i;
    logic [31:0]  encode_x_i;
    logic [2:0]   src_vld_i;
    logic [143:0] src_data_i;
    logic [2:0]   src_rdy_o;
    logic         aurora_almost_full_i;
    logic         aurora_vout_vld_o;
    logic [63:0]  aurora_vout_data_o;
    logic [2:0]   grant_o;
    logic         busy_o;
    logic         pad_evt_o;

    always #5 clk_i = ~clk_i;

    fbc_upload_arbiter #(
        .BURST_LEN   (BURST),
        .TIMEOUT_CYC (TMO),
        .HEADER_TAG  (8'hA5)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .scan_en_i            (scan_en_i),
        .fbc_up_en_i          (fbc_up_en_i),
        .encode_x_i           (encode_x_i),
        .src_vld_i            (src_vld_i),
        .src_data_i           (src_data_i),
        .src_rdy_o            (src_rdy_o),
        .aurora_almost_full_i (aurora_almost_full_i),
        .aurora_vout_vld_o    (aurora_vout_vld_o),
        .aurora_vout_data_o   (aurora_vout_data_o),
        .grant_o              (grant_o),
        .busy_o               (busy_o),
        .pad_evt_o            (pad_evt_o)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    // Commands applied to the DUT inputs on the next falling edge.
    logic        scan_cmd;
    logic        af_cmd;
    logic [2:0]  en_cmd;
    logic [31:0] enc_cmd;

    int         remaining[3];
    int         cnt[3];
    logic [2:0] hs;
    int         step_no;
    int         words_seen;
    int         pad_pulses;
    int         pad_step;
    int         last_hs1_step;
    bit         push_on_hs;
    int         pkt_accepts;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] sample_of(input int k, input int n);
        return {8'(k), 40'(n)};
    endfunction

    function automatic logic [63:0] hdr_word(input logic [1:0] ch, input logic [15:0] seq,
                                             input logic [31:0] enc);
        return {8'hA5, 6'd0, ch, seq, enc};
    endfunction

    function automatic logic [63:0] data_word(input logic [1:0] ch, input logic [47:0] s);
        return {8'h00, 6'd0, ch, s};
    endfunction

    function automatic logic [63:0] pad_word(input logic [1:0] ch);
        return {8'hFF, 6'd0, ch, 48'd0};
    endfunction

    // One clock cycle: drive inputs on the falling edge, then sample the
    // handshake and the registered outputs 1 time unit later.
    task automatic step();
        @(negedge clk_i);
        step_no++;
        for (int k = 0; k < 3; k++) begin
            if (hs[k]) begin
                cnt[k]++;
                remaining[k]--;
            end
        end
        scan_en_i            = scan_cmd;
        aurora_almost_full_i = af_cmd;
        fbc_up_en_i          = en_cmd;
        encode_x_i           = enc_cmd;
        for (int k = 0; k < 3; k++) begin
            src_vld_i[k]           = (remaining[k] > 0);
            src_data_i[48*k +: 48] = sample_of(k, cnt[k]);
        end
        #1;
        hs = src_vld_i & src_rdy_o;
        for (int k = 0; k < 3; k++) begin
            if (hs[k] && push_on_hs) begin
                exp_q.push_back(data_word(2'(k), sample_of(k, cnt[k])));
                pkt_accepts++;
            end
        end
        if (hs[1]) last_hs1_step = step_no;
        if (aurora_vout_vld_o) begin
            words_seen++;
            if (exp_q.size() == 0) check("extra_word_vld", 64'(aurora_vout_vld_o), 64'd0);
            else check($sformatf("word%0d", words_seen), aurora_vout_data_o, exp_q.pop_front());
        end
        if (pad_evt_o) begin
            pad_pulses++;
            pad_step = step_no;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || busy_o) && n < budget);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic wait_words(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (words_seen < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(words_seen >= target), 64'd1);
    endtask

    task automatic push_burst(input int k, input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(data_word(2'(k), sample_of(k, first + i)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[4];
        int pc[3];
        int ch0_before;
        int drop_step;
        int n;

        rst_i = 1'b1;
        scan_en_i = 1'b0; fbc_up_en_i = '0; encode_x_i = '0;
        src_vld_i = '0; src_data_i = '0; aurora_almost_full_i = 1'b0;
        scan_cmd = 1'b0; af_cmd = 1'b0; en_cmd = '0; enc_cmd = '0;
        for (int k = 0; k < 3; k++) begin
            remaining[k] = 0;
            cnt[k]       = 0;
        end
        hs = '0; step_no = 0; words_seen = 0; pad_pulses = 0; pad_step = -1;
        last_hs1_step = -1; push_on_hs = 1'b0; pkt_accepts = 0;

        // ---- reset state ----
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_vld",  64'(aurora_vout_vld_o), 64'd0);
        check("rst_data", aurora_vout_data_o, 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_pad",  64'(pad_evt_o), 64'd0);
        check("rst_rdy",  64'(src_rdy_o), 64'd0);
        rst_i = 1'b0;
        step(); step();

        // ---- T1: single channel, two packets, seq 0 then 1 ----
        scan_cmd = 1'b1; en_cmd = 3'b001; enc_cmd = 32'h123;
        exp_q.push_back(hdr_word(2'd0, 16'd0, 32'h123));
        push_burst(0, cnt[0], BURST);
        remaining[0] = BURST;
        words_seen = 0;
        n = 0;
        while (!busy_o && n < 10) begin step(); n++; end
        check("t1_grant", 64'(grant_o), 64'b001);
        drain("t1a", 100);
        check("t1a_len", 64'(words_seen), 64'd17);

        enc_cmd = 32'h456;
        exp_q.push_back(hdr_word(2'd0, 16'd1, 32'h456));
        push_burst(0, cnt[0], BURST);
        remaining[0] = BURST;
        drain("t1b", 100);

        // ---- asynchronous reset in the middle of a DATA burst ----
        enc_cmd = 32'h777;
        exp_q.push_back(hdr_word(2'd0, 16'd2, 32'h777));
        push_burst(0, cnt[0], BURST);
        remaining[0] = 40;
        words_seen = 0;
        wait_words("rst_mid_reach", 8, 100);
        check("rst_mid_busy_before", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        hs = '0;
        #1;
        check("rst_mid_vld",  64'(aurora_vout_vld_o), 64'd0);
        check("rst_mid_data", aurora_vout_data_o, 64'd0);
        check("rst_mid_grant", 64'(grant_o), 64'd0);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_rdy",  64'(src_rdy_o), 64'd0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) remaining[k] = 0;
        repeat (3) step();
        rst_i = 1'b0;
        step();

        // ---- T2: all channels pending, order 0,1,2,0 from reset ----
        en_cmd = 3'b111; enc_cmd = 32'hABCD;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        for (int k = 0; k < 3; k++) pc[k] = cnt[k];
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(hdr_word(2'(order[p]), 16'(p), 32'hABCD));
            push_burst(order[p], pc[order[p]], BURST);
            pc[order[p]] += BURST;
        end
        remaining[0] = 2 * BURST; remaining[1] = BURST; remaining[2] = BURST;
        words_seen = 0;
        drain("t2", 400);
        check("t2_len", 64'(words_seen), 64'd68);

        // ---- T3: almost-full for 10 cycles after beat 5 ----
        en_cmd = 3'b010; enc_cmd = 32'hBEEF;
        exp_q.push_back(hdr_word(2'd1, 16'd4, 32'hBEEF));
        push_burst(1, cnt[1], BURST);
        remaining[1] = BURST;
        words_seen = 0; pad_pulses = 0;
        wait_words("t3_reach", 7, 100);
        af_cmd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t3_rdy%0d", i), 64'(src_rdy_o), 64'd0);
            if (i > 0) check($sformatf("t3_vld%0d", i), 64'(aurora_vout_vld_o), 64'd0);
        end
        af_cmd = 1'b0;
        drain("t3", 100);
        check("t3_len", 64'(words_seen), 64'd17);
        check("t3_no_pad", 64'(pad_pulses), 64'd0);

        // ---- T4: ch1 stalls after 4 beats, timeout padding ----
        enc_cmd = 32'h4444;
        exp_q.push_back(hdr_word(2'd1, 16'd5, 32'h4444));
        push_burst(1, cnt[1], 4);
        for (int i = 0; i < BURST - 4; i++) exp_q.push_back(pad_word(2'd1));
        remaining[1] = 4;
        words_seen = 0; pad_pulses = 0; pad_step = -1; last_hs1_step = -1;
        drain("t4", 200);
        check("t4_len", 64'(words_seen), 64'd17);
        check("t4_pad_pulses", 64'(pad_pulses), 64'd1);
        check("t4_pad_delay", 64'(pad_step - last_hs1_step), 64'(TMO));

        // ---- T5: ch0 valid but disabled; en[2] cleared mid-packet ----
        en_cmd = 3'b100; enc_cmd = 32'h5555;
        ch0_before = cnt[0];
        remaining[0] = 5; remaining[2] = 100;
        exp_q.push_back(hdr_word(2'd2, 16'd6, 32'h5555));
        push_on_hs = 1'b1; pkt_accepts = 0;
        words_seen = 0; pad_pulses = 0; pad_step = -1;
        wait_words("t5_reach", 4, 100);
        check("t5_grant", 64'(grant_o), 64'b100);
        en_cmd = 3'b000;
        step();
        drop_step = step_no;
        push_on_hs = 1'b0;
        for (int i = pkt_accepts; i < BURST; i++) exp_q.push_back(pad_word(2'd2));
        drain("t5", 100);
        check("t5_len", 64'(words_seen), 64'd17);
        check("t5_pad_pulses", 64'(pad_pulses), 64'd1);
        check("t5_pad_delay", 64'(pad_step - drop_step), 64'd1);
        check("t5_ch0_untouched", 64'(cnt[0]), 64'(ch0_before));
        remaining[0] = 0; remaining[2] = 0;
        repeat (3) step();
        check("end_queue", 64'(exp_q.size()), 64'd0);
        check("end_idle", 64'(busy_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
